tiler_writer: RTL and testbench

Write-side address generator and beat sequencer for layer tiles. It takes one tiler instruction: nine mixed-radix loop sizes, nine strides and a base offset. It then pairs each incoming result beat with the DRAM write address for its position in the 9-digit loop nest. It sits between the layer output path and the DRAM write port, and mirrors the read-side tiler that fetches operands with the same instruction format.

---
 rtl/tiler_writer.sv | 102 ++++++++++
 tb/tb_tiler_writer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tiler_writer.sv
// tiler_writer: pairs result beats with DRAM write addresses walked through a 9-digit mixed-radix loop nest.
module tiler_writer #(
  parameter int TOTAL_DIGITS = 9,
  parameter int DIGIT_WIDTH  = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 576
) (
  input  logic                                    clk,
  input  logic                                    resetn,
  input  logic [2*TOTAL_DIGITS:0][DIGIT_WIDTH-1:0] instruc,
  input  logic                                    instruc_valid,
  output logic                                    instruc_ready,
  input  logic [DATA_WIDTH-1:0]                   din,
  input  logic                                    din_valid,
  output logic                                    din_ready,
  output logic [ADDR_WIDTH-1:0]                   wr_addr,
  output logic [DATA_WIDTH-1:0]                   wr_data,
  output logic                                    wr_last,
  output logic                                    wr_valid,
  input  logic                                    wr_ready,
  output logic                                    busy,
  output logic                                    done
);
  localparam int TD = TOTAL_DIGITS;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, nxt;
  logic [DIGIT_WIDTH-1:0] sz [TD];
  logic [DIGIT_WIDTH-1:0] c [TD];
  logic [ADDR_WIDTH-1:0] st [TD];
  // rb[i] = base + sum over j>=i of c_j*stride_j, so rb[0] is the current address
  logic [ADDR_WIDTH-1:0] rb [TD];
  logic [ADDR_WIDTH-1:0] nv [TD+1];
  logic [ADDR_WIDTH-1:0] bs;
  logic [TD-1:0] w;
  logic [TD:0] cy;
  logic din_hs, wr_hs;
  assign din_hs = din_valid && din_ready;
  assign wr_hs = wr_valid && wr_ready;
  always_comb begin
    cy[0] = 1'b1;
    for (int i = 0; i < TD; i++) begin
      w[i] = c[i] == (sz[i] == '0 ? DIGIT_WIDTH'(0) : sz[i] - DIGIT_WIDTH'(1));
      cy[i+1] = cy[i] && w[i];
    end
    nv[TD] = bs;
    for (int i = TD - 1; i >= 0; i--)
      nv[i] = !cy[i] ? rb[i] : w[i] ? nv[i+1] : rb[i] + st[i];
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (instruc_valid ? RUN : IDLE) :
          state == RUN   ? (din_hs && cy[TD] ? FLUSH : RUN) :
          state == FLUSH ? (wr_hs && wr_last ? IDLE : FLUSH) : IDLE;
  always_comb begin
    instruc_ready = state == IDLE;
    busy = state != IDLE;
    din_ready = state == RUN && (!wr_valid || wr_ready);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      bs <= '0;
      for (int i = 0; i < TD; i++) begin
        sz[i] <= '0;
        st[i] <= '0;
        c[i] <= '0;
        rb[i] <= '0;
      end
    end else if (state == IDLE && instruc_valid) begin
      bs <= ADDR_WIDTH'(instruc[2*TD]);
      for (int i = 0; i < TD; i++) begin
        sz[i] <= instruc[i];
        st[i] <= ADDR_WIDTH'(instruc[TD+i]);
        c[i] <= '0;
        rb[i] <= ADDR_WIDTH'(instruc[2*TD]);
      end
    end else if (din_hs)
      for (int i = 0; i < TD; i++) begin
        c[i] <= !cy[i] ? c[i] : w[i] ? '0 : c[i] + DIGIT_WIDTH'(1);
        rb[i] <= nv[i];
      end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_valid <= 1'b0;
      wr_last <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done <= 1'b0;
    end else begin
      done <= state == FLUSH && wr_hs && wr_last;
      if (din_hs) begin
        wr_valid <= 1'b1;
        wr_last <= cy[TD];
        wr_addr <= rb[0];
        wr_data <= din;
      end else if (wr_ready) begin
        wr_valid <= 1'b0;
        wr_last <= 1'b0;
      end
    end
endmodule

// File: tb/tb_tiler_writer.sv
// tb_tiler_writer: directed tiles with a scoreboard of expected writes built from a mixed-radix address model.
module tb_tiler_writer;
  localparam int TD = 9;
  localparam int DGW = 16;
  localparam int AW = 16;
  localparam int DW = 576;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic last;
  } wr_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [2*TD:0][DGW-1:0] instruc = '0;
  logic instruc_valid = 1'b0, instruc_ready;
  logic [DW-1:0] din = '0;
  logic din_valid = 1'b0, din_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic wr_last, wr_valid, busy, done;
  logic wr_ready = 1'b1;
  int vecs = 0, errs = 0;
  int tsz [TD];
  int tst [TD];
  int tbase;
  int salt = 0;
  wr_t q [$];
  tiler_writer #(.TOTAL_DIGITS(TD), .DIGIT_WIDTH(DGW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn), .instruc(instruc), .instruc_valid(instruc_valid),
    .instruc_ready(instruc_ready), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int beats();
    int n = 1;
    for (int i = 0; i < TD; i++) n *= (tsz[i] == 0) ? 1 : tsz[i];
    return n;
  endfunction
  function automatic logic [AW-1:0] exp_addr(input int k);
    int rem = k;
    longint acc = tbase;
    for (int i = 0; i < TD; i++) begin
      int e = (tsz[i] == 0) ? 1 : tsz[i];
      acc += longint'(rem % e) * longint'(tst[i]);
      rem /= e;
    end
    return AW'(acc);
  endfunction
  function automatic logic [DW-1:0] beat_data(input int k);
    logic [31:0] v = 32'(k) ^ (32'(salt) << 20) ^ 32'h5A000000;
    return {18{v}};
  endfunction
  task automatic run_tile(input int pat, input int abort);
    int n = beats();
    int sent = 0, got = 0;
    bit fin = 0;
    salt++;
    q.delete();
    @(negedge clk);
    for (int i = 0; i < TD; i++) begin
      instruc[i] = DGW'(tsz[i]);
      instruc[TD+i] = DGW'(tst[i]);
    end
    instruc[2*TD] = DGW'(tbase);
    instruc_valid = 1'b1;
    wr_ready = 1'b1;
    #1 chk("instruc_ready_idle", instruc_ready, 1'b1);
    for (int cyc = 0; cyc < 4 * n + 20; cyc++) begin
      @(negedge clk);
      instruc_valid = 1'b1;
      instruc = {(2*TD+1){16'hBEEF}};
      if (abort > 0 && sent == abort) begin
        din_valid = 1'b0;
        return;
      end
      wr_ready = pat == 0 ? 1'b1 : (cyc % 4 == 0 || cyc % 4 == 3);
      din_valid = sent < n;
      din = beat_data(sent);
      #1;
      if (cyc == 0) begin
        chk("busy_after_instr", busy, 1'b1);
        chk("din_ready_after_instr", din_ready, 1'b1);
      end
      if (fin) begin
        chk("done_pulse", done, 1'b1);
        chk("busy_after_done", busy, 1'b0);
        chk("instruc_ready_after_done", instruc_ready, 1'b1);
        chk("beat_count", got, n);
        instruc_valid = 1'b0;
        return;
      end
      if (wr_valid) begin
        if (q.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
        else begin
          chk("wr_addr", wr_addr, q[0].addr);
          chk("wr_data", wr_data, q[0].data);
          chk("wr_last", wr_last, q[0].last);
          chk("done_low", done, 1'b0);
          if (!wr_ready) chk("din_ready_stall", din_ready, 1'b0);
          if (wr_ready) begin
            void'(q.pop_front());
            got++;
            fin = got == n;
          end
        end
      end
      if (sent == n) chk("din_ready_flush", din_ready, 1'b0);
      if (din_valid && din_ready) begin
        q.push_back('{addr: exp_addr(sent), data: beat_data(sent), last: sent == n - 1});
        sent++;
      end
    end
    chk("tile_timeout", 1'b1, 1'b0);
    instruc_valid = 1'b0;
  endtask
  task automatic clear_tile();
    for (int i = 0; i < TD; i++) begin
      tsz[i] = 1;
      tst[i] = 0;
    end
  endtask
  initial begin
    #2;
    chk("rst_instruc_ready", instruc_ready, 1'b1);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_din_ready", din_ready, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    clear_tile();
    tsz[0] = 4; tsz[1] = 3; tst[0] = 1; tst[1] = 16; tbase = 'h100;
    run_tile(0, 0);
    run_tile(1, 0);
    for (int i = 0; i < TD; i++) begin
      tsz[i] = 0;
      tst[i] = 'h33;
    end
    tbase = 'h7;
    run_tile(0, 0);
    clear_tile();
    tsz[0] = 4; tst[0] = 1; tbase = (1 << AW) - 2;
    run_tile(0, 0);
    tsz[0] = 2; tsz[1] = 3; tst[1] = 'h8000; tbase = 'h1234;
    run_tile(1, 0);
    for (int i = 0; i < TD; i++) begin
      tsz[i] = 2;
      tst[i] = 1 << i;
    end
    tbase = 0;
    run_tile(0, 0);
    clear_tile();
    tsz[0] = 4; tsz[1] = 3; tst[0] = 1; tst[1] = 16; tbase = 'h100;
    run_tile(0, 5);
    resetn = 1'b0;
    #1;
    chk("mid_rst_wr_valid", wr_valid, 1'b0);
    chk("mid_rst_wr_last", wr_last, 1'b0);
    chk("mid_rst_wr_addr", wr_addr, '0);
    chk("mid_rst_wr_data", wr_data, '0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_din_ready", din_ready, 1'b0);
    chk("mid_rst_instruc_ready", instruc_ready, 1'b1);
    instruc_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tbase = 'h240;
    run_tile(1, 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
